// File: rtl/trap_ctrl_pkg.sv
//==============================================================================
// Module   : trap_ctrl_pkg
// Purpose  : Shared decode/CSR constants and trap sequencer state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package trap_ctrl_pkg;

   typedef enum logic [2:0] {
      IR_R = 3'd0,
      IR_I = 3'd1,
      IR_S = 3'd2,
      IR_B = 3'd3,
      IR_U = 3'd4,
      IR_J = 3'd5
   } ir_type_t;

   localparam logic [2:0] F3_PRIV  = 3'b000;
   localparam logic [2:0] F3_CSRRW = 3'b001;
   localparam logic [2:0] F3_CSRRS = 3'b010;
   localparam logic [2:0] F3_CSRRC = 3'b011;

   localparam logic [11:0] C_CSR_MEPC   = 12'h341;
   localparam logic [11:0] C_CSR_MCAUSE = 12'h342;

   localparam logic [31:0] C_CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] C_CAUSE_ECALL   = 32'd11;

   localparam int unsigned C_ST_W = 3;
   localparam logic [C_ST_W-1:0] S_IDLE     = 3'd0;
   localparam logic [C_ST_W-1:0] S_DRAIN    = 3'd1;
   localparam logic [C_ST_W-1:0] S_WR_EPC   = 3'd2;
   localparam logic [C_ST_W-1:0] S_WR_CAUSE = 3'd3;
   localparam logic [C_ST_W-1:0] S_REDIRECT = 3'd4;

   function automatic logic [31:0] cause_code(input logic is_ecall);
      return is_ecall ? C_CAUSE_ECALL : C_CAUSE_ILLEGAL;
   endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl.sv
//==============================================================================
// Module   : trap_ctrl
// Purpose  : Sequences ecall/illegal traps (drain, mepc/mcause write, vector)
//            and mret returns for a single-issue in-order pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic        is_ecall,
   input  logic        is_mret,
   input  logic        is_illegal_ir,
   input  logic        pipe_empty,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        stall,
   output logic        flush,
   output logic        csr_wr_en,
   output logic [11:0] csr_wr_addr,
   output logic [31:0] csr_wr_data,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        e_cause_is_ecall
);

   logic [C_ST_W-1:0] r_state;
   logic [C_ST_W-1:0] w_next_state;
   logic [31:0]       r_pc;
   logic              r_kind_ecall;
   logic              r_op_ret;
   logic              r_e_cause_is_ecall;
   logic              w_trap_ev;
   logic              w_ret_ev;

   // Illegal dominates ecall; an mret flagged illegal is treated as a trap.
   assign w_trap_ev = id_valid & (is_illegal_ir | is_ecall);
   assign w_ret_ev  = id_valid & is_mret & ~is_illegal_ir;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state            <= S_IDLE;
         r_pc               <= 32'd0;
         r_kind_ecall       <= 1'b0;
         r_op_ret           <= 1'b0;
         r_e_cause_is_ecall <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == S_IDLE) && (w_trap_ev || w_ret_ev)) begin
            r_op_ret <= ~w_trap_ev;
            if (w_trap_ev) begin
               r_pc         <= id_pc;
               r_kind_ecall <= ~is_illegal_ir;
            end
         end
         if (r_state == S_WR_CAUSE) begin
            r_e_cause_is_ecall <= r_kind_ecall;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_trap_ev || w_ret_ev) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pipe_empty) begin
               w_next_state = r_op_ret ? S_REDIRECT : S_WR_EPC;
            end
         end
         S_WR_EPC:   w_next_state = S_WR_CAUSE;
         S_WR_CAUSE: w_next_state = S_REDIRECT;
         S_REDIRECT: w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      stall       = 1'b0;
      flush       = 1'b0;
      csr_wr_en   = 1'b0;
      csr_wr_addr = 12'd0;
      csr_wr_data = 32'd0;
      pc_redirect = 1'b0;
      pc_target   = 32'd0;
      case (r_state)
         S_IDLE: begin
            stall = w_trap_ev | w_ret_ev;
            flush = w_trap_ev | w_ret_ev;
         end
         S_DRAIN: begin
            stall = 1'b1;
            flush = 1'b1;
         end
         S_WR_EPC: begin
            stall       = 1'b1;
            csr_wr_en   = 1'b1;
            csr_wr_addr = C_CSR_MEPC;
            csr_wr_data = r_pc;
         end
         S_WR_CAUSE: begin
            stall       = 1'b1;
            csr_wr_en   = 1'b1;
            csr_wr_addr = C_CSR_MCAUSE;
            csr_wr_data = cause_code(r_kind_ecall);
         end
         S_REDIRECT: begin
            flush       = 1'b1;
            pc_redirect = 1'b1;
            // Return past an ecall; re-execute after any other trap cause.
            pc_target   = r_op_ret ? (mepc + (r_e_cause_is_ecall ? 32'd4 : 32'd0)) : mtvec;
         end
         default: ;
      endcase
   end

   assign e_cause_is_ecall = r_e_cause_is_ecall;

endmodule

`default_nettype wire
